// File: rtl/wave_rom_arbiter_pkg.sv
// Shared types and defaults for the wave ROM SDRAM-port arbiter.
package wave_rom_arbiter_pkg;
  localparam int AW_DEF      = 25;
  localparam int RW_DEF      = 20;
  localparam int TIMEOUT_DEF = 63;
  localparam int NUM_CH      = 2;

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_e;

  // Keeps the low w bits of v; the callers cast the result to the memory address width.
  function automatic logic [63:0] zext(input logic [63:0] v, input int unsigned w);
    return (w >= 64) ? v : (v & ((64'd1 << w) - 64'd1));
  endfunction
endpackage

// File: rtl/wave_rd_slot.sv
// One sample-read channel: request capture, busy tracking and result register.
module wave_rd_slot
  import wave_rom_arbiter_pkg::*;
#(
  parameter int RW = RW_DEF
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          req_i,
  input  logic [RW-1:0] addr_i,
  input  logic          done_i,
  input  logic [15:0]   done_data_i,
  output logic          pend_o,
  output logic [RW-1:0] addr_o,
  output logic          busy_o,
  output logic          valid_o,
  output logic [15:0]   data_o
);
  logic          pend_q, pend_d, valid_q, valid_d, take;
  logic [RW-1:0] addr_q, addr_d;
  logic [15:0]   data_q, data_d;

  // Busy covers the result-strobe cycle so a request arriving with valid is dropped.
  assign busy_o  = pend_q | valid_q;
  assign take    = req_i & ~busy_o;
  assign pend_o  = pend_q | take;
  assign addr_o  = take ? addr_i : addr_q;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_comb begin
    pend_d  = pend_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = done_i;
    if (done_i) begin
      pend_d = 1'b0;
      data_d = done_data_i;
    end else if (take) begin
      pend_d = 1'b1;
      addr_d = addr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      pend_q  <= pend_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/wave_rom_arbiter.sv
// Serialises the ROM download writer and two sample readers onto one SDRAM port,
// one access in flight, with a watchdog on the controller acknowledge.
module wave_rom_arbiter
  import wave_rom_arbiter_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int RW      = RW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          dl_active_i,
  input  logic          dl_wr_i,
  input  logic [AW-1:0] dl_addr_i,
  input  logic [7:0]    dl_data_i,
  input  logic          rd0_req_i,
  input  logic [RW-1:0] rd0_addr_i,
  input  logic          rd1_req_i,
  input  logic [RW-1:0] rd1_addr_i,
  output logic [15:0]   rd0_data_o,
  output logic          rd0_valid_o,
  output logic          rd0_busy_o,
  output logic [15:0]   rd1_data_o,
  output logic          rd1_valid_o,
  output logic          rd1_busy_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_we_o,
  output logic          mem_rd_o,
  output logic [7:0]    mem_din_o,
  input  logic [15:0]   mem_dout_i,
  input  logic          mem_ack_i,
  output logic          dl_overflow_o,
  output logic          timeout_err_o
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [NUM_CH-1:0]         rd_req, rd_pend, rd_done, rd_valid, rd_busy;
  logic [NUM_CH-1:0][RW-1:0] rd_addr_in, rd_addr;
  logic [NUM_CH-1:0][15:0]   rd_data;
  logic [15:0]               done_data;

  assign rd_req     = {rd1_req_i, rd0_req_i};
  assign rd_addr_in = {rd1_addr_i, rd0_addr_i};

  wave_rd_slot #(.RW(RW)) u_slot [NUM_CH-1:0] (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_i       (rd_req),
    .addr_i      (rd_addr_in),
    .done_i      (rd_done),
    .done_data_i (done_data),
    .pend_o      (rd_pend),
    .addr_o      (rd_addr),
    .busy_o      (rd_busy),
    .valid_o     (rd_valid),
    .data_o      (rd_data)
  );

  assign {rd1_data_o, rd0_data_o}   = rd_data;
  assign {rd1_valid_o, rd0_valid_o} = rd_valid;
  assign {rd1_busy_o, rd0_busy_o}   = rd_busy;

  state_e        state_q, state_d;
  logic          wr_full_q, wr_full_d, last_q, last_d, cur_q, cur_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d, mem_addr_q, mem_addr_d;
  logic [7:0]    wr_data_q, wr_data_d, mem_din_q, mem_din_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_we_q, mem_we_d, mem_rd_q, mem_rd_d, ovf_q, ovf_d, tmo_q, tmo_d;
  logic          expired, wr_free, dl_take, wr_cap, gnt_ch;

  always_comb begin
    expired    = (cnt_q == CW'(TIMEOUT - 1));
    // The slot may refill in the very cycle its write completes or is aborted.
    wr_free    = (state_q == ST_WRITE) && (mem_ack_i || expired);
    dl_take    = dl_wr_i && dl_active_i;
    wr_cap     = dl_take && (!wr_full_q || wr_free);
    wr_full_d  = wr_cap || (wr_full_q && !wr_free);
    wr_addr_d  = wr_cap ? dl_addr_i : wr_addr_q;
    wr_data_d  = wr_cap ? dl_data_i : wr_data_q;
    ovf_d      = ovf_q || (dl_take && !wr_cap);
    state_d    = state_q;
    last_d     = last_q;
    cur_d      = cur_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_we_d   = 1'b0;
    mem_rd_d   = 1'b0;
    tmo_d      = tmo_q;
    rd_done    = '0;
    done_data  = mem_dout_i;
    gnt_ch     = (&rd_pend) ? ~last_q : rd_pend[1];
    case (state_q)
      ST_IDLE: begin
        if (wr_full_d) begin
          state_d    = ST_WRITE;
          mem_we_d   = 1'b1;
          mem_addr_d = wr_addr_d;
          mem_din_d  = wr_data_d;
          cnt_d      = '0;
        end else if (!dl_active_i && |rd_pend) begin
          state_d    = ST_READ;
          mem_rd_d   = 1'b1;
          mem_addr_d = AW'(zext(64'(rd_addr[gnt_ch]), RW));
          cur_d      = gnt_ch;
          last_d     = gnt_ch;
          cnt_d      = '0;
        end
      end
      ST_WRITE: begin
        if (wr_free) begin
          state_d = ST_IDLE;
          tmo_d   = tmo_q | !mem_ack_i;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READ: begin
        if (mem_ack_i || expired) begin
          rd_done[cur_q] = 1'b1;
          done_data      = mem_ack_i ? mem_dout_i : 16'h0000;
          tmo_d          = tmo_q | !mem_ack_i;
          state_d        = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      wr_full_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      last_q     <= 1'b1;
      cur_q      <= 1'b0;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
      ovf_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_full_q  <= wr_full_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      last_q     <= last_d;
      cur_q      <= cur_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_we_q   <= mem_we_d;
      mem_rd_q   <= mem_rd_d;
      ovf_q      <= ovf_d;
      tmo_q      <= tmo_d;
    end
  end

  assign mem_addr_o    = mem_addr_q;
  assign mem_din_o     = mem_din_q;
  assign mem_we_o      = mem_we_q;
  assign mem_rd_o      = mem_rd_q;
  assign dl_overflow_o = ovf_q;
  assign timeout_err_o = tmo_q;
endmodule
